// File: rtl/spw_tx_arbiter_if.sv
// Bundled requester, tx FIFO and status signals of the SpaceWire tx arbiter.
// master = requesters/FIFO side, slave = the arbiter.
interface spw_tx_arbiter_if;
  logic       req0Req;
  logic       req0WriteEnable;
  logic [8:0] req0DataIn;
  logic       req0Full;
  logic       req1Req;
  logic       req1WriteEnable;
  logic [8:0] req1DataIn;
  logic       req1Full;
  logic       txWriteEnable;
  logic [8:0] txDataIn;
  logic       txFull;
  logic [1:0] grant;
  logic       protocolError;
  logic       watchdogTrip;

  modport master (
    output req0Req, req0WriteEnable, req0DataIn, req1Req, req1WriteEnable, req1DataIn, txFull,
    input  req0Full, req1Full, txWriteEnable, txDataIn, grant, protocolError, watchdogTrip
  );

  modport slave (
    input  req0Req, req0WriteEnable, req0DataIn, req1Req, req1WriteEnable, req1DataIn, txFull,
    output req0Full, req1Full, txWriteEnable, txDataIn, grant, protocolError, watchdogTrip
  );
endinterface

// File: rtl/spw_tx_arbiter.sv
// Two-requester packet arbiter in front of a SpaceWire tx FIFO; whole packets, round-robin on contention.
// Optional packet-length watchdog with EEP abort is built when SPW_TX_ARB_WATCHDOG_EN is defined.
//
// state | meaning
// IDLE  | no owner; picks the next requester (the one other than last_grant on a tie)
// OWN0  | requester 0 streams characters straight through to the tx FIFO
// OWN1  | requester 1 streams characters straight through to the tx FIFO
// ABORT | (watchdog build) writes a single EEP for the over-length packet, then IDLE
module spw_tx_arbiter #(
  parameter int unsigned MAX_PKT_LEN = 4096
) (
  input logic            clk,
  input logic            rst,
  spw_tx_arbiter_if.slave bus
);

  if (MAX_PKT_LEN < 1 || MAX_PKT_LEN > 65535) begin : g_bad_len
    $error("MAX_PKT_LEN must be within 1..65535");
  end

`ifdef SPW_TX_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, ABORT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
`endif

  state_t     state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic [1:0] grant_q, grant_nxt;
  logic       perr_q, perr_nxt;
  logic [1:0] discard;
  logic [1:0] pend, owner, full, we;
  logic       own_idx, own_we, acc;
  logic [8:0] own_data;
  logic       tx_we;
  logic [8:0] tx_data;

`ifdef SPW_TX_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_LEN);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       discard_nxt, eop;
  logic             trip_q, trip_nxt;
  logic             abort_idx, abort_idx_nxt;

  assign eop = {bus.req1DataIn[8], bus.req0DataIn[8]};
`else
  assign discard = 2'b00;
`endif

  assign we = {bus.req1WriteEnable, bus.req0WriteEnable};

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    perr_nxt       = perr_q;
    tx_we          = 1'b0;
    tx_data        = '0;
    full           = ~discard;
    owner          = 2'b00;
    pend           = {bus.req1Req, bus.req0Req} & ~discard;
    own_idx        = (state == OWN1);
    own_we         = own_idx ? bus.req1WriteEnable : bus.req0WriteEnable;
    own_data       = own_idx ? bus.req1DataIn : bus.req0DataIn;
    acc            = own_we & ~bus.txFull;
`ifdef SPW_TX_ARB_WATCHDOG_EN
    cnt_nxt        = cnt;
    discard_nxt    = discard;
    trip_nxt       = 1'b0;
    abort_idx_nxt  = abort_idx;
`endif

    case (state)
      IDLE: begin
`ifdef SPW_TX_ARB_WATCHDOG_EN
        cnt_nxt = '0;
`endif
        if (&pend)
          state_nxt = last_grant ? OWN0 : OWN1;
        else if (pend[0])
          state_nxt = OWN0;
        else if (pend[1])
          state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        owner[own_idx] = 1'b1;
        full[own_idx]  = bus.txFull;
        tx_data        = own_data;
        tx_we          = acc;
        if (acc && own_data[8]) begin
          state_nxt      = IDLE;
          last_grant_nxt = own_idx;
        end
`ifdef SPW_TX_ARB_WATCHDOG_EN
        // The character that would exceed the limit is swallowed, not forwarded.
        if (acc && !own_data[8] && cnt == CNT_MAX) begin
          tx_we                = 1'b0;
          state_nxt            = ABORT;
          trip_nxt             = 1'b1;
          discard_nxt[own_idx] = 1'b1;
          abort_idx_nxt        = own_idx;
        end else if (acc && !own_data[8]) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
`ifdef SPW_TX_ARB_WATCHDOG_EN
      ABORT: begin
        full    = 2'b11;
        tx_data = 9'h101;
        tx_we   = ~bus.txFull;
        cnt_nxt = '0;
        if (!bus.txFull) begin
          state_nxt      = IDLE;
          last_grant_nxt = abort_idx;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    for (int i = 0; i < 2; i++) begin
      if (we[i] && !discard[i] && !owner[i])
        perr_nxt = 1'b1;
`ifdef SPW_TX_ARB_WATCHDOG_EN
      if (we[i] && discard[i] && eop[i])
        discard_nxt[i] = 1'b0;
`endif
    end
  end

  // grant is registered from the next state so it lines up with the state register.
  always_comb begin
    grant_nxt = 2'b00;
    case (state_nxt)
      OWN0:    grant_nxt = 2'b01;
      OWN1:    grant_nxt = 2'b10;
`ifdef SPW_TX_ARB_WATCHDOG_EN
      ABORT:   grant_nxt = abort_idx_nxt ? 2'b10 : 2'b01;
`endif
      default: grant_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_q    <= 2'b00;
      perr_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_q    <= grant_nxt;
      perr_q     <= perr_nxt;
    end
  end

`ifdef SPW_TX_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      discard   <= 2'b00;
      trip_q    <= 1'b0;
      abort_idx <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      discard   <= discard_nxt;
      trip_q    <= trip_nxt;
      abort_idx <= abort_idx_nxt;
    end
  end

  assign bus.watchdogTrip = trip_q;
`else
  assign bus.watchdogTrip = 1'b0;
`endif

  assign bus.txWriteEnable = tx_we;
  assign bus.txDataIn      = tx_data;
  assign bus.req0Full      = full[0];
  assign bus.req1Full      = full[1];
  assign bus.grant         = grant_q;
  assign bus.protocolError = perr_q;

endmodule

// File: tb/tb_spw_tx_arbiter.sv
// Testbench for spw_tx_arbiter: random packets checked against a packet-level model of arbitration,
// forwarding and (when SPW_TX_ARB_WATCHDOG_EN is defined) the length watchdog.
module tb_spw_tx_arbiter;
  localparam int WD_MAX = 4;
`ifdef SPW_TX_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef logic [8:0] chr_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;

  spw_tx_arbiter_if bus ();

  spw_tx_arbiter #(.MAX_PKT_LEN(WD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         fails     = 0;
  logic [8:0] tx_log[$];
  logic [1:0] grant_log[$];
  logic [8:0] exp_q[$];
  int         trip_cnt  = 0;
  int         full_viol = 0;
  bit         model_last = 1'b1;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.txWriteEnable === 1'b1) tx_log.push_back(bus.txDataIn);
      if (bus.txWriteEnable === 1'b1 && bus.txFull === 1'b1) full_viol++;
      if (bus.watchdogTrip === 1'b1) trip_cnt++;
      grant_log.push_back(bus.grant);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Expected characters on the tx FIFO for one whole packet: everything up to the end marker,
  // or, with the watchdog, the first WD_MAX data characters followed by an EEP.
  function automatic bit model_pkt(input chr_q_t pkt);
    int n = 0;
    logic [8:0] c;
    foreach (pkt[i]) begin
      c = pkt[i];
      if (c[8]) begin
        exp_q.push_back(c);
        return 1'b0;
      end
      if (WD_EN && n == WD_MAX) begin
        exp_q.push_back(9'h101);
        return 1'b1;
      end
      exp_q.push_back(c);
      n++;
    end
    return 1'b0;
  endfunction

  function automatic int stream_diff();
    int n = (tx_log.size() < exp_q.size()) ? tx_log.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (tx_log[i] !== exp_q[i]) return i;
    if (tx_log.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic make_pkt(input int n_data, input int eop_sel, output chr_q_t q);
    q = {};
    for (int i = 0; i < n_data; i++) q.push_back({1'b0, 8'($urandom_range(0, 255))});
    if (eop_sel == 0)      q.push_back(9'h100);
    else if (eop_sel == 1) q.push_back(9'h101);
    else                   q.push_back(9'h100 | 9'($urandom_range(0, 1)));
  endtask

  task automatic clear_logs();
    tx_log    = {};
    grant_log = {};
    exp_q     = {};
    trip_cnt  = 0;
    full_viol = 0;
  endtask

  task automatic drive_wr(input int idx, input logic w, input logic [8:0] d);
    if (idx == 0) begin bus.req0WriteEnable = w; bus.req0DataIn = d; end
    else          begin bus.req1WriteEnable = w; bus.req1DataIn = d; end
  endtask

  task automatic set_req(input int idx, input logic v);
    if (idx == 0) bus.req0Req = v;
    else          bus.req1Req = v;
  endtask

  function automatic logic full_of(input int idx);
    return (idx == 0) ? bus.req0Full : bus.req1Full;
  endfunction

  task automatic zero_inputs();
    bus.req0Req = 0; bus.req0WriteEnable = 0; bus.req0DataIn = '0;
    bus.req1Req = 0; bus.req1WriteEnable = 0; bus.req1DataIn = '0;
    bus.txFull  = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b1;
  endtask

  // Requester driver: holds req, writes one character whenever its Full is low.
  task automatic send_pkt(input int idx, input chr_q_t chars, input int budget, output bit ok);
    int  i = 0;
    int  cyc = 0;
    bit  wrote;
    @(posedge clk); #2;
    set_req(idx, 1'b1);
    while (i < chars.size() && cyc < budget) begin
      if (full_of(idx) === 1'b0) begin drive_wr(idx, 1'b1, chars[i]); wrote = 1; end
      else                       begin drive_wr(idx, 1'b0, '0);       wrote = 0; end
      @(posedge clk); #2;
      if (wrote) i++;
      cyc++;
    end
    drive_wr(idx, 1'b0, '0);
    set_req(idx, 1'b0);
    ok = (i == chars.size());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    zero_inputs();
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
    tests_run++; if ({bus.req1Full, bus.req0Full} !== 2'b11) begin fails++; $display("FAIL reset_full: got %b want 11", {bus.req1Full, bus.req0Full}); end
    tests_run++; if (bus.txWriteEnable !== 1'b0 || bus.txDataIn !== 9'h000) begin fails++; $display("FAIL reset_tx: got we=%b data=%h want 0/000", bus.txWriteEnable, bus.txDataIn); end
    tests_run++; if (bus.protocolError !== 1'b0 || bus.watchdogTrip !== 1'b0) begin fails++; $display("FAIL reset_flags: got perr=%b trip=%b want 0/0", bus.protocolError, bus.watchdogTrip); end
    rst = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL reset_idle_grant: got %b want 00", bus.grant); end
  endtask

  task automatic test_single();
    chr_q_t pkt;
    bit ok;
    int d;
    clear_logs();
    make_pkt(4, 0, pkt);
    void'(model_pkt(pkt));
    fork
      send_pkt(0, pkt, 100, ok);
      begin
        @(posedge bus.req0Req);
        @(negedge clk);
        tests_run++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL single_grant_early: got %b want 00", bus.grant); end
        @(negedge clk);
        tests_run++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL single_grant: got %b want 01", bus.grant); end
      end
    join
    model_last = 1'b0;
    tests_run++; if (!ok) begin fails++; $display("FAIL single_done: got incomplete want all 5 accepted"); end
    tests_run++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL single_idle: got %b want 00", bus.grant); end
    d = stream_diff();
    tests_run++; if (d != -1) begin fails++; $display("FAIL single_stream: differs at %0d, got %0d chars want %0d", d, tx_log.size(), exp_q.size()); end
  endtask

  task automatic test_back_to_back(input bit with_reset);
    chr_q_t p0, p1;
    bit ok0, ok1;
    int first, d, a, b, late;
    logic [1:0] g1, g2;
    if (with_reset) do_reset();
    clear_logs();
    make_pkt($urandom_range(1, WD_MAX), 2, p0);
    make_pkt($urandom_range(1, WD_MAX), 2, p1);
    first = model_last ? 0 : 1;
    if (first == 0) begin void'(model_pkt(p0)); void'(model_pkt(p1)); end
    else            begin void'(model_pkt(p1)); void'(model_pkt(p0)); end
    fork
      send_pkt(0, p0, 200, ok0);
      send_pkt(1, p1, 200, ok1);
    join
    model_last = (first == 0);
    g1 = (first == 0) ? 2'b01 : 2'b10;
    g2 = ~g1;
    a = -1; b = -1; late = 0;
    foreach (grant_log[k]) if (b < 0 && grant_log[k] === g2) b = k;
    foreach (grant_log[k]) if (grant_log[k] === g1) begin
      if (b >= 0 && k > b) late++;
      else a = k;
    end
    tests_run++; if (!(ok0 && ok1)) begin fails++; $display("FAIL b2b_done(rst=%0d): got ok0=%0d ok1=%0d want 1/1", with_reset, ok0, ok1); end
    d = stream_diff();
    tests_run++; if (d != -1) begin fails++; $display("FAIL b2b_stream(rst=%0d): differs at %0d, got %0d chars want %0d", with_reset, d, tx_log.size(), exp_q.size()); end
    tests_run++; if (b < 0 || a < 0 || b - a != 2 || late != 0) begin fails++; $display("FAIL b2b_order(rst=%0d): got first-owner end %0d second start %0d late %0d want gap 2 late 0", with_reset, a, b, late); end
  endtask

  task automatic test_txfull_random();
    chr_q_t pkt;
    bit ok, tr, done;
    int d;
    clear_logs();
    make_pkt(15, 2, pkt);
    tr = model_pkt(pkt);
    done = 0;
    fork
      begin send_pkt(0, pkt, 400, ok); done = 1; end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.txFull = 1'($urandom_range(0, 1));
        end
        bus.txFull = 1'b0;
      end
    join
    model_last = 1'b0;
    repeat (4) @(posedge clk);
    tests_run++; if (!ok) begin fails++; $display("FAIL txfull_done: got incomplete want all 16 accepted"); end
    tests_run++; if (full_viol != 0) begin fails++; $display("FAIL txfull_gate: got %0d writes with txFull want 0", full_viol); end
    d = stream_diff();
    tests_run++; if (d != -1) begin fails++; $display("FAIL txfull_stream: differs at %0d, got %0d chars want %0d", d, tx_log.size(), exp_q.size()); end
    tests_run++; if (trip_cnt != int'(tr)) begin fails++; $display("FAIL txfull_trip: got %0d pulses want %0d", trip_cnt, tr); end
  endtask

  task automatic test_protocol_error();
    chr_q_t pkt;
    bit ok;
    int d;
    clear_logs();
    make_pkt(5, 2, pkt);
    void'(model_pkt(pkt));
    tests_run++; if (bus.protocolError !== 1'b0) begin fails++; $display("FAIL perr_clean: got %b want 0", bus.protocolError); end
    fork
      send_pkt(0, pkt, 100, ok);
      begin
        int n = 0;
        while (bus.grant !== 2'b01 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #2;
        bus.req1WriteEnable = 1'b1; bus.req1DataIn = 9'h0AA;
        @(posedge clk); #2;
        bus.req1WriteEnable = 1'b0; bus.req1DataIn = 9'h000;
      end
    join
    model_last = 1'b0;
    tests_run++; if (bus.protocolError !== 1'b1) begin fails++; $display("FAIL perr_set: got %b want 1", bus.protocolError); end
    d = stream_diff();
    tests_run++; if (d != -1 || !ok) begin fails++; $display("FAIL perr_stream: differs at %0d (ok=%0d), got %0d chars want %0d", d, ok, tx_log.size(), exp_q.size()); end
    repeat (5) @(negedge clk);
    tests_run++; if (bus.protocolError !== 1'b1) begin fails++; $display("FAIL perr_sticky: got %b want 1", bus.protocolError); end
    do_reset();
    @(negedge clk);
    tests_run++; if (bus.protocolError !== 1'b0) begin fails++; $display("FAIL perr_cleared: got %b want 0", bus.protocolError); end
  endtask

  task automatic test_watchdog();
    chr_q_t p0, p1;
    bit ok0, ok1, tr;
    int d, a, b;
    do_reset();
    clear_logs();
    make_pkt(6, 0, p0);
    make_pkt(3, 2, p1);
    tr = model_pkt(p0);
    void'(model_pkt(p1));
    fork
      send_pkt(0, p0, 200, ok0);
      send_pkt(1, p1, 200, ok1);
    join
    model_last = 1'b1;
    repeat (2) @(posedge clk);
    a = -1; b = -1;
    foreach (grant_log[k]) if (b < 0 && grant_log[k] === 2'b10) b = k;
    foreach (grant_log[k]) if (grant_log[k] === 2'b01 && (b < 0 || k < b)) a = k;
    tests_run++; if (!(ok0 && ok1)) begin fails++; $display("FAIL wd_done: got ok0=%0d ok1=%0d want 1/1", ok0, ok1); end
    d = stream_diff();
    tests_run++; if (d != -1) begin fails++; $display("FAIL wd_stream: differs at %0d, got %0d chars want %0d", d, tx_log.size(), exp_q.size()); end
    tests_run++; if (trip_cnt != int'(tr)) begin fails++; $display("FAIL wd_trip: got %0d pulses want %0d", trip_cnt, tr); end
    tests_run++; if (bus.protocolError !== 1'b0) begin fails++; $display("FAIL wd_perr: got %b want 0", bus.protocolError); end
    tests_run++; if (a < 0 || b - a != 2) begin fails++; $display("FAIL wd_next_owner: got req0 end %0d req1 start %0d want gap 2", a, b); end
  endtask

  task automatic test_reset_mid();
    chr_q_t p0, p1;
    bit ok0, ok1;
    int marks, d, firstg;
    do_reset();
    clear_logs();
    @(posedge clk); #2;
    bus.req0Req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (bus.req0Full === 1'b0) drive_wr(0, 1'b1, {1'b0, 8'($urandom_range(0, 255))});
      else                       drive_wr(0, 1'b0, '0);
      @(posedge clk); #2;
    end
    drive_wr(0, 1'b1, 9'h05A);
    #1 rst = 1'b0;
    #1;
    tests_run++; if (bus.txWriteEnable !== 1'b0 || bus.txDataIn !== 9'h000) begin fails++; $display("FAIL mid_tx: got we=%b data=%h want 0/000", bus.txWriteEnable, bus.txDataIn); end
    tests_run++; if ({bus.req1Full, bus.req0Full} !== 2'b11 || bus.grant !== 2'b00) begin fails++; $display("FAIL mid_ctrl: got full=%b grant=%b want 11/00", {bus.req1Full, bus.req0Full}, bus.grant); end
    marks = 0;
    foreach (tx_log[k]) if (tx_log[k][8]) marks++;
    tests_run++; if (marks != 0 || tx_log.size() == 0) begin fails++; $display("FAIL mid_partial: got %0d markers in %0d chars want 0 markers, >0 chars", marks, tx_log.size()); end
    zero_inputs();
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b1;
    clear_logs();
    make_pkt(2, 2, p0);
    make_pkt(2, 2, p1);
    void'(model_pkt(p0));
    void'(model_pkt(p1));
    fork
      send_pkt(0, p0, 200, ok0);
      send_pkt(1, p1, 200, ok1);
    join
    firstg = 0;
    foreach (grant_log[k]) if (firstg == 0 && grant_log[k] !== 2'b00) firstg = int'(grant_log[k]);
    tests_run++; if (firstg != 1) begin fails++; $display("FAIL mid_restart_owner: got grant %0d want 1", firstg); end
    d = stream_diff();
    tests_run++; if (d != -1 || !(ok0 && ok1)) begin fails++; $display("FAIL mid_restart_stream: differs at %0d, got %0d chars want %0d", d, tx_log.size(), exp_q.size()); end
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_single();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_txfull_random();
    test_protocol_error();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/spw_tx_arbiter.md
SPW_TX_ARBITER -- requirements
Module: spw_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_PKT_LEN, default 4096, meaning the maximum data characters per packet before the watchdog trips (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req0Req  input  1  requester 0 has a packet pending; held high until its end marker is accepted.
REQ-005 SHALL have port req0WriteEnable  input  1  requester 0 character strobe.
REQ-006 SHALL have port req0DataIn  input  9  requester 0 character; bit8=1 means end marker (8'h00 = EOP, 8'h01 = EEP).
REQ-007 SHALL have port req0Full  output  1  requester 0 must not write this cycle.
REQ-008 SHALL have ports req1Req, req1WriteEnable, req1DataIn and req1Full, identical to REQ-004..007, for requester 1.
REQ-009 SHALL have port txWriteEnable  output  1  write strobe to the SpaceWire tx FIFO.
REQ-010 SHALL have port txDataIn  output  9  character to the tx FIFO.
REQ-011 SHALL have port txFull  input  1  tx FIFO full.
REQ-012 SHALL have port grant  output  2  one-hot current owner (bit0 = requester 0); 2'b00 when none.
REQ-013 SHALL have port protocolError  output  1  sticky flag: a non-owner wrote.
REQ-014 SHALL have port watchdogTrip  output  1  one-cycle pulse when a packet is aborted.

Function
REQ-015 SHALL implement FSM states IDLE, OWN0, OWN1 and ABORT.
REQ-016 In IDLE: one pending requester -> its OWN state next cycle; both pending -> the requester other than lastGrant wins; none pending -> stay in IDLE.
REQ-017 In OWNx: txWriteEnable = reqxWriteEnable & !txFull and txDataIn = reqxDataIn, both combinational (zero latency).
REQ-018 reqxFull = txFull when owner; 1 when not owner; 0 while the discard flag for x is set (REQ-022).
REQ-019 An accepted character with bit8=1 in OWNx -> IDLE next cycle, lastGrant <= x; this gives a minimum 1-cycle gap between packets.
REQ-020 A write from a non-owner whose discard flag is clear SHALL be dropped and SHALL set protocolError; protocolError is cleared only by reset.
REQ-021 Dropping req in OWNx without an end marker SHALL NOT release ownership.
REQ-022 Discard flag x, set by an abort: each write from x is accepted and dropped; the flag clears when x writes bit8=1, and x is not granted while the flag is set.
REQ-023 Simultaneous rising req0Req and req1Req with lastGrant=0 SHALL grant requester 1.
REQ-024 grant SHALL be a registered decode of the state; ABORT shows the aborted owner.

Reset
REQ-025 Asserting rst SHALL force immediately: state IDLE, lastGrant = 1, grant = 0, protocolError = 0, watchdogTrip = 0, counter = 0, discard flags = 0.
REQ-026 Reset SHALL abandon any packet mid-transfer without inserting an end marker.
REQ-027 Reset outputs SHALL be txWriteEnable = 0, txDataIn = 0, req0Full = req1Full = 1.

Configuration
REQ-028 Macro SPW_TX_ARB_WATCHDOG_EN defined: a counter of width clog2(MAX_PKT_LEN+1) counts accepted data characters (bit8=0) of the current packet and clears on IDLE.
REQ-029 With the macro, counter == MAX_PKT_LEN and owner x writing a data character: that character is dropped; ABORT entered; discard flag x set; watchdogTrip pulses.
REQ-030 In ABORT: reqFull = 1 for both requesters; txDataIn = 9'h101 (EEP) is written once when !txFull; then IDLE with lastGrant <= x.
REQ-031 Macro undefined: no counter, no ABORT state, no discard flags, watchdogTrip tied to 0, MAX_PKT_LEN ignored.

Verification
REQ-032 Bench SHALL cover: req0 alone sends 4 data characters + 9'h100 with txFull = 0 -> grant = 01 one cycle after req; 5 tx writes in order; IDLE after the end marker.
REQ-033 Bench SHALL cover: req0 and req1 asserted in the same cycle after reset -> req0 first, req1 granted exactly 1 cycle after req0's EOP, no interleaving.
REQ-034 Bench SHALL cover: random txFull during a 16-character packet -> txWriteEnable never high with txFull; all 16 characters delivered unchanged.
REQ-035 Bench SHALL cover: req1 writes 8'hAA while req0 owns -> nothing forwarded from req1; protocolError = 1 until reset.
REQ-036 Bench SHALL cover, with watchdog macro and MAX_PKT_LEN = 4: req0 writes 6 data characters then EOP -> 4 forwarded, then 9'h101, watchdogTrip pulses once, remaining characters and EOP dropped, req1 is served next.
REQ-037 Bench SHALL cover: rst asserted mid-packet -> outputs take reset values asynchronously; the next packet starts clean with req0 priority.
